regfile_rename: RTL and testbench

//  Architectural register file with per-register rename tags, directly downstream of the ROB.

---
 rtl/regfile_rename_if.sv | 26 ++
 rtl/regfile_rename.sv | 51 +++++
 tb/tb_regfile_rename.sv | 106 ++++++++++
 3 files changed

// File: rtl/regfile_rename_if.sv
// regfile_rename_if: ROB rename/commit, flush and dispatch read bundle for the renamed register file
interface regfile_rename_if #(parameter int DATA_W = 32, parameter int NICK_W = 5);
  logic              rdy;
  logic              clr;
  logic              nick_en;
  logic [NICK_W-1:0] nick;
  logic [4:0]        nick_regnm;
  logic              cmt_en;
  logic [4:0]        rd_regnm;
  logic [DATA_W-1:0] rd_dt;
  logic [NICK_W-1:0] rd_nick;
  logic [4:0]        rs1_regnm;
  logic [4:0]        rs2_regnm;
  logic [DATA_W-1:0] rs1_dt;
  logic [NICK_W-1:0] rs1_nick;
  logic [DATA_W-1:0] rs2_dt;
  logic [NICK_W-1:0] rs2_nick;
  modport master (
    output rdy, clr, nick_en, nick, nick_regnm, cmt_en, rd_regnm, rd_dt, rd_nick, rs1_regnm, rs2_regnm,
    input  rs1_dt, rs1_nick, rs2_dt, rs2_nick
  );
  modport slave (
    input  rdy, clr, nick_en, nick, nick_regnm, cmt_en, rd_regnm, rd_dt, rd_nick, rs1_regnm, rs2_regnm,
    output rs1_dt, rs1_nick, rs2_dt, rs2_nick
  );
endinterface

// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with per-register ROB rename tags and commit bypass
module regfile_rename #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32,
  parameter int NICK_W  = 5
) (
  input logic            clk,
  input logic            rst_n,
  regfile_rename_if.slave bus
);
  logic [DATA_W-1:0] val [REG_NUM];
  logic [NICK_W-1:0] tag [REG_NUM];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val[i] <= '0;
        tag[i] <= '0;
      end
    end else if (bus.rdy) begin
      if (bus.clr) begin
        for (int i = 0; i < REG_NUM; i++) tag[i] <= '0;
      end else begin
        if (bus.cmt_en && bus.rd_regnm != '0) begin
          val[bus.rd_regnm] <= bus.rd_dt;
          if (tag[bus.rd_regnm] == bus.rd_nick) tag[bus.rd_regnm] <= '0;
        end
        // a same-edge rename is written last so it overrides the commit's tag clear
        if (bus.nick_en && bus.nick_regnm != '0) tag[bus.nick_regnm] <= bus.nick;
      end
    end
  end
  logic [4:0]        rs [2];
  logic [DATA_W-1:0] dt [2];
  logic [NICK_W-1:0] nk [2];
  assign rs[0] = bus.rs1_regnm;
  assign rs[1] = bus.rs2_regnm;
  for (genvar s = 0; s < 2; s++) begin : g_rd
    logic [NICK_W-1:0] t;
    logic              byp;
    logic              z;
    assign t   = tag[rs[s]];
    assign z   = rs[s] == '0;
    assign byp = bus.cmt_en && !bus.clr && bus.rd_regnm == rs[s] && t == bus.rd_nick && t != '0;
    assign dt[s] = z ? '0 : byp ? bus.rd_dt : t != '0 ? '0 : val[rs[s]];
    assign nk[s] = (z || byp) ? '0 : t;
  end
  assign bus.rs1_dt   = dt[0];
  assign bus.rs1_nick = nk[0];
  assign bus.rs2_dt   = dt[1];
  assign bus.rs2_nick = nk[1];
endmodule

// File: tb/tb_regfile_rename.sv
// tb_regfile_rename: directed rename/commit/flush/reset sequence with hand-computed expectations
module tb_regfile_rename;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  regfile_rename_if #(.DATA_W(32), .NICK_W(5)) bus ();
  regfile_rename #(.REG_NUM(32), .DATA_W(32), .NICK_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic rd(input string name, input logic [4:0] a, input logic [4:0] b,
                    input logic [31:0] d1, input logic [4:0] n1, input logic [31:0] d2, input logic [4:0] n2);
    bus.rs1_regnm = a;
    bus.rs2_regnm = b;
    #1;
    chk({name, "_rs1_dt"}, bus.rs1_dt, d1);
    chk({name, "_rs1_nick"}, {27'd0, bus.rs1_nick}, {27'd0, n1});
    chk({name, "_rs2_dt"}, bus.rs2_dt, d2);
    chk({name, "_rs2_nick"}, {27'd0, bus.rs2_nick}, {27'd0, n2});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.clr = 0;
    bus.nick_en = 0;
    bus.cmt_en = 0;
  endtask
  task automatic ren(input logic [4:0] r, input logic [4:0] n);
    bus.nick_en = 1;
    bus.nick_regnm = r;
    bus.nick = n;
  endtask
  task automatic cmt(input logic [4:0] r, input logic [4:0] n, input logic [31:0] d);
    bus.cmt_en = 1;
    bus.rd_regnm = r;
    bus.rd_nick = n;
    bus.rd_dt = d;
  endtask
  initial begin
    rst_n = 0;
    bus.rdy = 1;
    idle();
    bus.nick = 0; bus.nick_regnm = 0; bus.rd_regnm = 0; bus.rd_dt = 0; bus.rd_nick = 0;
    bus.rs1_regnm = 0; bus.rs2_regnm = 0;
    #12;
    rd("reset", 5'd5, 5'd7, 32'h0, 5'd0, 32'h0, 5'd0);
    @(negedge clk);
    rst_n = 1;
    tick();
    cmt(5, 3, 32'h1234); tick(); idle();
    rd("cmt_notag", 5'd5, 5'd0, 32'h1234, 5'd0, 32'h0, 5'd0);
    ren(7, 4); tick(); idle();
    rd("ren_x7", 5'd7, 5'd5, 32'h0, 5'd4, 32'h1234, 5'd0);
    cmt(7, 4, 32'hAA);
    rd("bypass_x7", 5'd7, 5'd7, 32'hAA, 5'd0, 32'hAA, 5'd0);
    tick(); idle();
    rd("cmt_clear_x7", 5'd7, 5'd0, 32'hAA, 5'd0, 32'h0, 5'd0);
    ren(5, 7);
    rd("no_same_cyc_ren", 5'd5, 5'd0, 32'h1234, 5'd0, 32'h0, 5'd0);
    idle();
    ren(7, 4); tick();
    ren(7, 9); tick(); idle();
    cmt(7, 4, 32'h55);
    rd("old_cmt_nobyp", 5'd7, 5'd0, 32'h0, 5'd9, 32'h0, 5'd0);
    tick(); idle();
    rd("younger_tag", 5'd7, 5'd0, 32'h0, 5'd9, 32'h0, 5'd0);
    bus.clr = 1; tick(); idle();
    rd("val_after_clr", 5'd7, 5'd5, 32'h55, 5'd0, 32'h1234, 5'd0);
    ren(3, 2); tick(); idle();
    cmt(3, 2, 32'h77); ren(3, 6); tick(); idle();
    rd("same_edge", 5'd3, 5'd0, 32'h0, 5'd6, 32'h0, 5'd0);
    bus.clr = 1; tick(); idle();
    rd("same_edge_val", 5'd3, 5'd0, 32'h77, 5'd0, 32'h0, 5'd0);
    ren(1, 5); tick();
    ren(2, 6); tick(); idle();
    rd("pre_flush", 5'd1, 5'd2, 32'h0, 5'd5, 32'h0, 5'd6);
    bus.clr = 1; cmt(1, 5, 32'hDEAD); ren(4, 8);
    rd("flush_nobyp", 5'd1, 5'd2, 32'h0, 5'd5, 32'h0, 5'd6);
    tick(); idle();
    rd("post_flush", 5'd1, 5'd2, 32'h0, 5'd0, 32'h0, 5'd0);
    rd("flush_ren_ign", 5'd4, 5'd3, 32'h0, 5'd0, 32'h77, 5'd0);
    ren(0, 3); cmt(0, 0, 32'hFFFF);
    rd("x0_same", 5'd0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0);
    tick(); idle();
    rd("x0_after", 5'd0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0);
    bus.rdy = 0; cmt(5, 0, 32'h9999); ren(6, 3); tick(); idle();
    bus.rdy = 1;
    rd("rdy_freeze", 5'd5, 5'd6, 32'h1234, 5'd0, 32'h0, 5'd0);
    ren(6, 3); tick(); idle();
    rd("pre_rst", 5'd5, 5'd6, 32'h1234, 5'd0, 32'h0, 5'd3);
    rst_n = 0;
    rd("async_rst", 5'd5, 5'd6, 32'h0, 5'd0, 32'h0, 5'd0);
    tick();
    rst_n = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
